// File: rtl/concat_packer.sv
// Packs NUM IN_W-bit chunks into one word; out_valid follows the final-chunk accept by 1 cycle.
// Only the final chunk stalls on a busy output slot. CONCAT_PACKER_FLUSH_EN adds padded partial flush.
module concat_packer #(
   parameter int IN_W = 4,
   parameter int NUM  = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [IN_W-1:0]          in_data_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic                     msb_first_i,
`ifdef CONCAT_PACKER_FLUSH_EN
   input  logic                     flush_i,
   input  logic                     pad_bit_i,
`endif
   output logic [IN_W*NUM-1:0]      out_data_o,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [$clog2(NUM+1)-1:0] fill_cnt_o
);
   localparam int OUT_W = IN_W * NUM;
   localparam int CW    = $clog2(NUM + 1);

   logic [OUT_W-1:0] acc_q, acc_d, out_data_q, out_data_d, merged;
   logic [CW-1:0]    fill_q, fill_d;
   logic             msb_q, msb_d, out_vld_q, out_vld_d;
   logic             slot_free, last, accept, msb_eff;

   assign slot_free   = !out_vld_q || out_ready_i;
   assign last        = (fill_q == CW'(NUM - 1));
   assign in_ready_o  = !last || slot_free;
   assign accept      = in_valid_i && in_ready_o;
   // Order is taken live on slot 0 so the first chunk needs no extra cycle.
   assign msb_eff     = (fill_q == '0) ? msb_first_i : msb_q;
   assign out_data_o  = out_data_q;
   assign out_valid_o = out_vld_q;
   assign fill_cnt_o  = fill_q;

   // Unfilled slots of acc are always zero, so the chunk can be dropped in place.
   always_comb begin
      merged = acc_q;
      for (int k = 0; k < NUM; k++) begin
         if (accept && fill_q == CW'(k)) begin
            if (msb_eff) merged[(NUM-1-k)*IN_W +: IN_W] = in_data_i;
            else         merged[k*IN_W +: IN_W]         = in_data_i;
         end
      end
   end

`ifdef CONCAT_PACKER_FLUSH_EN
   logic [OUT_W-1:0] padded;
   logic [CW-1:0]    filled;
   logic             do_flush;

   assign filled   = accept ? fill_q + CW'(1) : fill_q;
   assign do_flush = flush_i && slot_free && (fill_q != '0 || accept);

   always_comb begin
      padded = merged;
      for (int k = 0; k < NUM; k++) begin
         if (CW'(k) >= filled) begin
            if (msb_eff) padded[(NUM-1-k)*IN_W +: IN_W] = {IN_W{pad_bit_i}};
            else         padded[k*IN_W +: IN_W]         = {IN_W{pad_bit_i}};
         end
      end
   end
`endif

   always_comb begin
      acc_d      = acc_q;
      fill_d     = fill_q;
      msb_d      = msb_q;
      out_data_d = out_data_q;
      out_vld_d  = out_vld_q;
      if (out_vld_q && out_ready_i) out_vld_d = 1'b0;
      if (accept) begin
         if (fill_q == '0) msb_d = msb_first_i;
         acc_d  = merged;
         fill_d = fill_q + CW'(1);
      end
      if (accept && last) begin
         out_data_d = merged;
         out_vld_d  = 1'b1;
         acc_d      = '0;
         fill_d     = '0;
      end
`ifdef CONCAT_PACKER_FLUSH_EN
      else if (do_flush) begin
         out_data_d = padded;
         out_vld_d  = 1'b1;
         acc_d      = '0;
         fill_d     = '0;
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         acc_q      <= '0;
         fill_q     <= '0;
         msb_q      <= 1'b0;
         out_data_q <= '0;
         out_vld_q  <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         fill_q     <= fill_d;
         msb_q      <= msb_d;
         out_data_q <= out_data_d;
         out_vld_q  <= out_vld_d;
      end
   end
endmodule

// File: tb/tb_concat_packer.sv
// Scoreboard bench for concat_packer: NUM=2 instance for most cases, NUM=3 instance for streaming.
module tb_concat_packer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int ncmp = 0;
   int nerr = 0;

   // NUM=2 instance
   logic [3:0] a_in_data = '0;
   logic       a_in_valid = 1'b0, a_in_ready, a_msb = 1'b1, a_out_ready = 1'b1, a_out_valid;
   logic [7:0] a_out_data;
   logic [1:0] a_fill;
   logic       a_flush = 1'b0, a_pad = 1'b0;
   logic [15:0] a_exp[$];

   // NUM=3 instance
   logic [3:0]  b_in_data = '0;
   logic        b_in_valid = 1'b0, b_in_ready, b_out_valid;
   logic [11:0] b_out_data;
   logic [1:0]  b_fill;
   logic [15:0] b_exp[$];

   concat_packer #(.IN_W(4), .NUM(2)) u_a (
      .clk_i(clk), .rst_n_i(rst_n),
      .in_data_i(a_in_data), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
      .msb_first_i(a_msb),
`ifdef CONCAT_PACKER_FLUSH_EN
      .flush_i(a_flush), .pad_bit_i(a_pad),
`endif
      .out_data_o(a_out_data), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
      .fill_cnt_o(a_fill)
   );

   concat_packer #(.IN_W(4), .NUM(3)) u_b (
      .clk_i(clk), .rst_n_i(rst_n),
      .in_data_i(b_in_data), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
      .msb_first_i(1'b1),
`ifdef CONCAT_PACKER_FLUSH_EN
      .flush_i(1'b0), .pad_bit_i(1'b0),
`endif
      .out_data_o(b_out_data), .out_valid_o(b_out_valid), .out_ready_i(1'b1),
      .fill_cnt_o(b_fill)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: a word is consumed on the edge following a valid&ready sample.
   always @(negedge clk) begin
      if (a_out_valid && a_out_ready) begin
         if (a_exp.size() == 0) begin
            ncmp++; nerr++;
            $display("FAIL a_unexpected: got 0x%0h expected no word", a_out_data);
         end else chk("a_word", {8'h0, a_out_data}, a_exp.pop_front());
      end
      if (b_out_valid) begin
         if (b_exp.size() == 0) begin
            ncmp++; nerr++;
            $display("FAIL b_unexpected: got 0x%0h expected no word", b_out_data);
         end else chk("b_word", {4'h0, b_out_data}, b_exp.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Present a chunk to instance A and hold it until accepted (bounded).
   task automatic send_a(input logic [3:0] d);
      bit acc;
      a_in_data  = d;
      a_in_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         acc = a_in_ready;
         tick();
      end
      a_in_valid = 1'b0;
      if (!acc) begin
         ncmp++; nerr++;
         $display("FAIL a_accept_timeout: chunk 0x%0h never accepted", d);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] seq_d[6];
      logic [1:0] seq_f[6];
      seq_d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
      seq_f = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};

      // Reset
      tick(); tick();
      chk("rst_out_valid", {15'h0, a_out_valid}, 16'h0);
      chk("rst_fill",      {14'h0, a_fill},      16'h0);
      chk("rst_out_data",  {8'h0, a_out_data},   16'h0);
      chk("rst_in_ready",  {15'h0, a_in_ready},  16'h1);
      rst_n = 1'b1;
      tick();

      // 1: msb-first packing and 1-cycle latency
      a_msb = 1'b1;
      a_exp.push_back(16'h35);
      send_a(4'b0011);
      chk("t1_fill_after_first", {14'h0, a_fill}, 16'h1);
      send_a(4'b0101);
      chk("t1_latency_valid", {15'h0, a_out_valid}, 16'h1);
      chk("t1_fill_wrap",     {14'h0, a_fill},      16'h0);
      tick();

      // 2: lsb-first, order latched at slot 0
      a_msb = 1'b0;
      a_exp.push_back(16'hAF);
      send_a(4'b1111);
      a_msb = 1'b1;
      send_a(4'b1010);
      tick();

      // 3: backpressure; partial fills, final chunk stalls, no bubble
      a_out_ready = 1'b0;
      a_exp.push_back(16'h12);
      send_a(4'h1);
      send_a(4'h2);
      send_a(4'b0110);
      chk("t3_partial_fill", {14'h0, a_fill}, 16'h1);
      a_in_data  = 4'b1101;
      a_in_valid = 1'b1;
      tick(); tick();
      chk("t3_in_ready_stall", {15'h0, a_in_ready}, 16'h0);
      chk("t3_held_data",      {8'h0, a_out_data},  16'h12);
      chk("t3_held_valid",     {15'h0, a_out_valid}, 16'h1);
      a_exp.push_back(16'h6D);
      a_out_ready = 1'b1;
      tick();
      a_in_valid = 1'b0;
      chk("t3_nobubble_valid", {15'h0, a_out_valid}, 16'h1);
      chk("t3_nobubble_data",  {8'h0, a_out_data},  16'h6D);
      tick(); tick();
      chk("t3_drained", {15'h0, a_out_valid}, 16'h0);

      // 4: NUM=3 continuous stream
      chk("t4_fill_start", {14'h0, b_fill}, 16'h0);
      b_exp.push_back(16'h123);
      b_exp.push_back(16'h456);
      for (int i = 0; i < 6; i++) begin
         b_in_data  = seq_d[i];
         b_in_valid = 1'b1;
         tick();
         chk($sformatf("t4_fill_%0d", i), {14'h0, b_fill}, {14'h0, seq_f[i]});
      end
      b_in_valid = 1'b0;
      tick(); tick();

      // 5: reset discards a partial word
      send_a(4'b1010);
      chk("t5_fill_before_rst", {14'h0, a_fill}, 16'h1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t5_rst_fill",  {14'h0, a_fill},      16'h0);
      chk("t5_rst_valid", {15'h0, a_out_valid}, 16'h0);
      a_msb = 1'b1;
      a_exp.push_back(16'h12);
      send_a(4'b0001);
      send_a(4'b0010);
      tick(); tick();

`ifdef CONCAT_PACKER_FLUSH_EN
      // 6: padded flush of a partial word, flush with nothing held ignored
      a_msb = 1'b1;
      a_pad = 1'b1;
      send_a(4'b1010);
      a_exp.push_back(16'hAF);
      a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
      chk("t6_flush_valid", {15'h0, a_out_valid}, 16'h1);
      chk("t6_flush_data",  {8'h0, a_out_data},  16'hAF);
      chk("t6_flush_fill",  {14'h0, a_fill},      16'h0);
      tick();
      a_flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_empty_flush", {15'h0, a_out_valid}, 16'h0);
      end
      a_flush = 1'b0;
      tick();
`endif

      tick(); tick();
      chk("a_queue_empty", 16'(a_exp.size()), 16'h0);
      chk("b_queue_empty", 16'(b_exp.size()), 16'h0);
      $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
      $finish;
   end
endmodule
